br_checkpoint_ctrl: RTL and testbench

- Manages the branch-checkpoint store for the rename map table.
- On branch dispatch, it captures the map table's branch snapshot (tag table plus ready bits) into a free slot and returns the checkpoint id.
- While a checkpoint is live, it keeps the stored ready bits current from the CDB.
- On a mispredict, it drives the recovery request and recovery tables into the map table, then frees the mispredicted checkpoint and every younger one.

---
 rtl/br_checkpoint_ctrl_pkg.sv | 42 ++++
 rtl/br_checkpoint_ctrl_ckpt_slot.sv | 71 +++++++
 rtl/br_checkpoint_ctrl.sv | 157 +++++++++++++++
 tb/tb_br_checkpoint_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/br_checkpoint_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// br_checkpoint_ctrl_pkg
// Shared definitions for the branch-checkpoint controller and its slots:
// the physical tag width, the default number of checkpoint slots, the layout
// of one stored checkpoint, and a helper that compares a full tag table
// against the two CDB broadcast tags.
// ---------------------------------------------------------------------------
`ifndef N_ENTRY_ROB
`define N_ENTRY_ROB 32
`endif

package br_checkpoint_ctrl_pkg;

  localparam int TAG_W          = $clog2(`N_ENTRY_ROB + 33);
  localparam int N_CKPT_DEFAULT = 4;
  localparam int N_ARCH_REG     = 32;
  // The zero register never waits on a producer.
  localparam int ZERO_REG       = 31;

  typedef struct packed {
    logic                             valid;
    logic                             resolved;
    logic [N_ARCH_REG-1:0]            ready;
    logic [N_ARCH_REG-1:0][TAG_W-1:0] tag;
  } ckpt_entry_t;

  // One bit per architectural register: set when that register's tag is
  // being broadcast on either CDB port this cycle.
  function automatic logic [N_ARCH_REG-1:0] cdbMatch(
    input logic [N_ARCH_REG-1:0][TAG_W-1:0] tags,
    input logic [TAG_W-1:0]                 cdb0,
    input logic [TAG_W-1:0]                 cdb1
  );
    logic [N_ARCH_REG-1:0] hits;
    hits = '0;
    for (int i = 0; i < N_ARCH_REG; i++) begin
      hits[i] = (tags[i] == cdb0) || (tags[i] == cdb1);
    end
    return hits;
  endfunction

endpackage

// File: rtl/br_checkpoint_ctrl_ckpt_slot.sv
// ---------------------------------------------------------------------------
// ckpt_slot
// One checkpoint entry of the branch-checkpoint store.
// Ports:
//   clock, reset    clock and synchronous active-high reset
//   clear_i         pipeline flush: drop the entry
//   write_i         capture a new snapshot (valid=1, resolved=0)
//   writeReady_i    ready-bit snapshot to capture
//   writeTag_i      tag snapshot to capture
//   cdb0_i, cdb1_i  completing tags; matching registers become ready
//   invalidate_i    drop the entry (retire or mispredict squash)
//   setResolved_i   the branch owning this entry resolved correctly
//   entry_o         current stored entry
// ---------------------------------------------------------------------------
module ckpt_slot
  import br_checkpoint_ctrl_pkg::*;
(
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             clear_i,
  input  logic                             write_i,
  input  logic [N_ARCH_REG-1:0]            writeReady_i,
  input  logic [N_ARCH_REG-1:0][TAG_W-1:0] writeTag_i,
  input  logic [TAG_W-1:0]                 cdb0_i,
  input  logic [TAG_W-1:0]                 cdb1_i,
  input  logic                             invalidate_i,
  input  logic                             setResolved_i,
  output ckpt_entry_t                      entry_o
);

  ckpt_entry_t entry_q, entry_d;

  // Next-state of the entry. A write loads a fresh snapshot; otherwise a live
  // entry keeps absorbing CDB wakeups so that a later recovery restores
  // up-to-date ready bits. Flush overrides everything except reset.
  always_comb begin
    entry_d = entry_q;
    if (write_i) begin
      entry_d.valid           = 1'b1;
      entry_d.resolved        = 1'b0;
      entry_d.tag             = writeTag_i;
      entry_d.ready           = writeReady_i;
      entry_d.ready[ZERO_REG] = 1'b1;
    end else begin
      if (entry_q.valid) begin
        entry_d.ready = entry_q.ready | cdbMatch(entry_q.tag, cdb0_i, cdb1_i);
      end
      if (setResolved_i) begin
        entry_d.resolved = 1'b1;
      end
      if (invalidate_i) begin
        entry_d.valid = 1'b0;
      end
    end
    if (clear_i) begin
      entry_d.valid = 1'b0;
    end
  end

  // Entry register with synchronous reset to an empty slot.
  always_ff @(posedge clock) begin
    if (reset) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign entry_o = entry_q;

endmodule

// File: rtl/br_checkpoint_ctrl.sv
// ---------------------------------------------------------------------------
// br_checkpoint_ctrl
// Branch-checkpoint store for the rename map table. Each dispatched branch
// gets a snapshot of the map table in a circular buffer of N_CKPT slots;
// a mispredict drives that snapshot back into the map table and squashes
// the mispredicted checkpoint plus every younger one.
// Ports:
//   clock, reset            clock and synchronous active-high reset
//   br_dispatch             branch dispatched: take a snapshot
//   snap_ready_table/_tag_  snapshot from the map table
//   CDB_in_0, CDB_in_1      completing tags
//   br_resolve_valid/_id    a branch resolved, and its checkpoint id
//   br_mispredict           that branch was mispredicted
//   flush                   full pipeline flush
//   ckpt_id_out             id the dispatching branch receives (tail)
//   ckpt_full               no free slot
//   ckpt_count              number of live checkpoints
//   recovery_br             map-table recovery request
//   recovery_*_table        tables to restore (zero when not recovering)
// ---------------------------------------------------------------------------
module br_checkpoint_ctrl
  import br_checkpoint_ctrl_pkg::*;
#(
  parameter int N_CKPT = N_CKPT_DEFAULT,
  parameter int CKPT_W = $clog2(N_CKPT)
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             br_dispatch,
  input  logic [N_ARCH_REG-1:0]            snap_ready_table,
  input  logic [N_ARCH_REG-1:0][TAG_W-1:0] snap_tag_table,
  input  logic [TAG_W-1:0]                 CDB_in_0,
  input  logic [TAG_W-1:0]                 CDB_in_1,
  input  logic                             br_resolve_valid,
  input  logic [CKPT_W-1:0]                br_resolve_id,
  input  logic                             br_mispredict,
  input  logic                             flush,
  output logic [CKPT_W-1:0]                ckpt_id_out,
  output logic                             ckpt_full,
  output logic [CKPT_W:0]                  ckpt_count,
  output logic                             recovery_br,
  output logic [N_ARCH_REG-1:0]            recovery_ready_table,
  output logic [N_ARCH_REG-1:0][TAG_W-1:0] recovery_Tag_table
);

  logic [CKPT_W-1:0] head_q, head_d;
  logic [CKPT_W-1:0] tail_q, tail_d;
  logic [CKPT_W:0]   count_q, count_d;

  ckpt_entry_t       entries [N_CKPT];
  logic [N_CKPT-1:0] slotValid;
  logic [N_CKPT-1:0] slotResolved;
  logic [N_CKPT-1:0] slotWrite;
  logic [N_CKPT-1:0] slotInvalidate;
  logic [N_CKPT-1:0] slotSetResolved;
  logic [CKPT_W-1:0] slotAge [N_CKPT];

  ckpt_entry_t       resEntry;
  logic              correctResolve;
  logic              retire;
  logic              alloc;
  logic [CKPT_W-1:0] misAge;

  for (genvar j = 0; j < N_CKPT; j++) begin : gSlot
    ckpt_slot uSlot (
      .clock        (clock),
      .reset        (reset),
      .clear_i      (flush),
      .write_i      (slotWrite[j]),
      .writeReady_i (snap_ready_table),
      .writeTag_i   (snap_tag_table),
      .cdb0_i       (CDB_in_0),
      .cdb1_i       (CDB_in_1),
      .invalidate_i (slotInvalidate[j]),
      .setResolved_i(slotSetResolved[j]),
      .entry_o      (entries[j])
    );
  end

  assign ckpt_full   = (count_q == (CKPT_W+1)'(N_CKPT));
  assign ckpt_id_out = tail_q;
  assign ckpt_count  = count_q;
  assign resEntry    = entries[br_resolve_id];

  // Recovery path is purely combinational so the map table can restore in
  // the resolve cycle. This cycle's CDB wakeups are folded into the restored
  // ready bits, otherwise they would be lost with the squashed state.
  always_comb begin
    recovery_br          = br_resolve_valid & br_mispredict & resEntry.valid & ~flush;
    recovery_ready_table = '0;
    recovery_Tag_table   = '0;
    if (recovery_br) begin
      recovery_Tag_table             = resEntry.tag;
      recovery_ready_table           = resEntry.ready
                                     | cdbMatch(resEntry.tag, CDB_in_0, CDB_in_1);
      recovery_ready_table[ZERO_REG] = 1'b1;
    end
  end

  // Per-slot control. Age is the distance from head, so "k and everything
  // younger" is every slot whose age is at least that of k. A mispredict on
  // the head itself must not also count as a retire.
  always_comb begin
    correctResolve = br_resolve_valid & ~br_mispredict & resEntry.valid & ~flush;
    alloc          = br_dispatch & ~ckpt_full & ~recovery_br & ~flush;
    misAge         = br_resolve_id - head_q;
    for (int j = 0; j < N_CKPT; j++) begin
      slotValid[j]    = entries[j].valid;
      slotResolved[j] = entries[j].resolved;
      slotAge[j]      = CKPT_W'(j) - head_q;
    end
    retire = slotValid[head_q] & slotResolved[head_q] & ~flush
           & ~(recovery_br && (br_resolve_id == head_q));
    for (int j = 0; j < N_CKPT; j++) begin
      slotWrite[j]       = alloc && (tail_q == CKPT_W'(j));
      slotSetResolved[j] = correctResolve && (br_resolve_id == CKPT_W'(j));
      slotInvalidate[j]  = (retire && (head_q == CKPT_W'(j)))
                        || (recovery_br && (slotAge[j] >= misAge));
    end
  end

  // Pointer and occupancy update. Flush empties the store; a mispredict
  // rewinds tail to the squashed id and drops any same-cycle dispatch;
  // otherwise allocation and retirement move tail and head independently.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else if (recovery_br) begin
      tail_d  = br_resolve_id;
      head_d  = head_q + CKPT_W'(retire);
      count_d = {1'b0, misAge} - (CKPT_W+1)'(retire);
    end else begin
      tail_d  = tail_q + CKPT_W'(alloc);
      head_d  = head_q + CKPT_W'(retire);
      count_d = count_q + (CKPT_W+1)'(alloc) - (CKPT_W+1)'(retire);
    end
  end

  // Pointer registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_br_checkpoint_ctrl.sv
// ---------------------------------------------------------------------------
// tb_br_checkpoint_ctrl
// Directed bench for br_checkpoint_ctrl with N_CKPT = 4: a vector table for
// the allocate / full / mispredict / flush sequence, then hand-written
// sequences for CDB-refreshed recovery, squash of younger checkpoints,
// in-order retirement, same-cycle mispredict+dispatch, flush and reset.
// ---------------------------------------------------------------------------
module tb_br_checkpoint_ctrl;
  import br_checkpoint_ctrl_pkg::*;

  localparam int N_CKPT = 4;
  localparam int CKPT_W = 2;

  logic                             clock = 1'b0;
  logic                             reset;
  logic                             br_dispatch;
  logic [N_ARCH_REG-1:0]            snap_ready_table;
  logic [N_ARCH_REG-1:0][TAG_W-1:0] snap_tag_table;
  logic [TAG_W-1:0]                 CDB_in_0;
  logic [TAG_W-1:0]                 CDB_in_1;
  logic                             br_resolve_valid;
  logic [CKPT_W-1:0]                br_resolve_id;
  logic                             br_mispredict;
  logic                             flush;
  logic [CKPT_W-1:0]                ckpt_id_out;
  logic                             ckpt_full;
  logic [CKPT_W:0]                  ckpt_count;
  logic                             recovery_br;
  logic [N_ARCH_REG-1:0]            recovery_ready_table;
  logic [N_ARCH_REG-1:0][TAG_W-1:0] recovery_Tag_table;

  int compared   = 0;
  int mismatched = 0;

  br_checkpoint_ctrl #(.N_CKPT(N_CKPT), .CKPT_W(CKPT_W)) dut (
    .clock               (clock),
    .reset               (reset),
    .br_dispatch         (br_dispatch),
    .snap_ready_table    (snap_ready_table),
    .snap_tag_table      (snap_tag_table),
    .CDB_in_0            (CDB_in_0),
    .CDB_in_1            (CDB_in_1),
    .br_resolve_valid    (br_resolve_valid),
    .br_resolve_id       (br_resolve_id),
    .br_mispredict       (br_mispredict),
    .flush               (flush),
    .ckpt_id_out         (ckpt_id_out),
    .ckpt_full           (ckpt_full),
    .ckpt_count          (ckpt_count),
    .recovery_br         (recovery_br),
    .recovery_ready_table(recovery_ready_table),
    .recovery_Tag_table  (recovery_Tag_table)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic             dispatch;
    logic             resValid;
    logic [1:0]       resId;
    logic             mispredict;
    logic             doFlush;
    logic [TAG_W-1:0] tag5;
    logic [1:0]       expId;
    logic             expFull;
    logic [2:0]       expCount;
    logic             expRec;
    logic [TAG_W-1:0] expRecTag5;
  } vec_t;

  vec_t vecs [12];

  // Compare one value and report any difference.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Snapshot used unless a test overrides it: tags 64+i never collide with
  // an idle CDB value of 0, only the zero register is ready.
  task automatic setDefaultSnapshot();
    for (int i = 0; i < N_ARCH_REG; i++) snap_tag_table[i] = TAG_W'(64 + i);
    snap_ready_table = 32'h8000_0000;
  endtask

  task automatic driveIdle();
    br_dispatch      = 1'b0;
    br_resolve_valid = 1'b0;
    br_resolve_id    = '0;
    br_mispredict    = 1'b0;
    flush            = 1'b0;
    CDB_in_0         = '0;
    CDB_in_1         = '0;
  endtask

  task automatic applyStimulus(input vec_t v);
    driveIdle();
    setDefaultSnapshot();
    br_dispatch       = v.dispatch;
    br_resolve_valid  = v.resValid;
    br_resolve_id     = v.resId;
    br_mispredict     = v.mispredict;
    flush             = v.doFlush;
    snap_tag_table[5] = v.tag5;
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkPtrs(input string tag, input logic [1:0] id, input logic full,
                           input logic [2:0] cnt);
    checkOutput({tag, ".id"},    32'(ckpt_id_out), 32'(id));
    checkOutput({tag, ".full"},  32'(ckpt_full),   32'(full));
    checkOutput({tag, ".count"}, 32'(ckpt_count),  32'(cnt));
  endtask

  task automatic doFlush();
    driveIdle();
    flush = 1'b1;
    tick();
    driveIdle();
  endtask

  task automatic dispatchN(input int n);
    for (int i = 0; i < n; i++) begin
      driveIdle();
      br_dispatch = 1'b1;
      tick();
    end
    driveIdle();
  endtask

  initial begin
    //            disp  rv    id    mis   fl    tag5     id    full  cnt   rec   recTag5
    vecs[0]  = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 7'd69, 2'd0, 1'b0, 3'd0, 1'b0, 7'd0};
    vecs[1]  = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 7'd69, 2'd1, 1'b0, 3'd1, 1'b0, 7'd0};
    vecs[2]  = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 7'd40, 2'd2, 1'b0, 3'd2, 1'b0, 7'd0};
    vecs[3]  = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 7'd69, 2'd3, 1'b0, 3'd3, 1'b0, 7'd0};
    vecs[4]  = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 7'd69, 2'd0, 1'b1, 3'd4, 1'b0, 7'd0};
    vecs[5]  = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 7'd69, 2'd0, 1'b1, 3'd4, 1'b0, 7'd0};
    vecs[6]  = '{1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 7'd69, 2'd0, 1'b1, 3'd4, 1'b1, 7'd40};
    vecs[7]  = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 7'd69, 2'd2, 1'b0, 3'd2, 1'b0, 7'd0};
    vecs[8]  = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 7'd69, 2'd2, 1'b0, 3'd2, 1'b0, 7'd0};
    vecs[9]  = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 7'd69, 2'd0, 1'b0, 3'd0, 1'b0, 7'd0};
    vecs[10] = '{1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 7'd69, 2'd0, 1'b0, 3'd0, 1'b0, 7'd0};
    vecs[11] = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 7'd69, 2'd0, 1'b0, 3'd0, 1'b0, 7'd0};

    // Reset state.
    driveIdle();
    setDefaultSnapshot();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checkPtrs("reset", 2'd0, 1'b0, 3'd0);
    checkOutput("reset.recovery_br",    32'(recovery_br), 32'd0);
    checkOutput("reset.recovery_ready", recovery_ready_table, 32'd0);

    // Fill, overflow, mispredict id 2, flush, stale mispredict.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkPtrs($sformatf("vec%0d", i), vecs[i].expId, vecs[i].expFull, vecs[i].expCount);
      checkOutput($sformatf("vec%0d.recovery_br", i), 32'(recovery_br), 32'(vecs[i].expRec));
      checkOutput($sformatf("vec%0d.recTag5", i), 32'(recovery_Tag_table[5]),
                  32'(vecs[i].expRecTag5));
      tick();
    end
    driveIdle();
    setDefaultSnapshot();

    // CDB wakeup two cycles after dispatch reaches the restored ready bits.
    doFlush();
    snap_tag_table[3] = 7'd37;
    br_dispatch = 1'b1;
    tick();
    driveIdle();
    setDefaultSnapshot();
    tick();
    CDB_in_0 = 7'd37;
    tick();
    driveIdle();
    br_resolve_valid = 1'b1;
    br_resolve_id    = 2'd0;
    br_mispredict    = 1'b1;
    #1;
    checkOutput("cdb.recovery_br", 32'(recovery_br), 32'd1);
    checkOutput("cdb.recTag3",     32'(recovery_Tag_table[3]), 32'd37);
    checkOutput("cdb.recReady3",   32'(recovery_ready_table[3]), 32'd1);
    checkOutput("cdb.recReady4",   32'(recovery_ready_table[4]), 32'd0);
    checkOutput("cdb.recReady31",  32'(recovery_ready_table[31]), 32'd1);
    tick();
    driveIdle();
    checkPtrs("cdb.after", 2'd0, 1'b0, 3'd0);

    // Mispredict id 1 squashes 1..3; the next dispatch reuses id 1.
    doFlush();
    dispatchN(4);
    br_resolve_valid = 1'b1;
    br_resolve_id    = 2'd1;
    br_mispredict    = 1'b1;
    #1;
    checkOutput("squash.recovery_br", 32'(recovery_br), 32'd1);
    tick();
    driveIdle();
    checkPtrs("squash.after", 2'd1, 1'b0, 3'd1);
    br_resolve_valid = 1'b1;
    br_mispredict    = 1'b1;
    br_resolve_id    = 2'd2;
    #1;
    checkOutput("squash.slot2", 32'(recovery_br), 32'd0);
    br_resolve_id = 2'd3;
    #1;
    checkOutput("squash.slot3", 32'(recovery_br), 32'd0);
    br_resolve_id = 2'd0;
    #1;
    checkOutput("squash.slot0", 32'(recovery_br), 32'd1);
    driveIdle();
    br_dispatch = 1'b1;
    #1;
    checkOutput("squash.nextId", 32'(ckpt_id_out), 32'd1);
    tick();
    driveIdle();
    checkPtrs("squash.realloc", 2'd2, 1'b0, 3'd2);

    // Out-of-order correct resolves retire in order, one per cycle.
    doFlush();
    dispatchN(2);
    checkPtrs("retire.start", 2'd2, 1'b0, 3'd2);
    br_resolve_valid = 1'b1;
    br_resolve_id    = 2'd1;
    tick();
    driveIdle();
    checkPtrs("retire.res1", 2'd2, 1'b0, 3'd2);
    tick();
    checkPtrs("retire.wait", 2'd2, 1'b0, 3'd2);
    br_resolve_valid = 1'b1;
    br_resolve_id    = 2'd0;
    tick();
    driveIdle();
    checkPtrs("retire.res0", 2'd2, 1'b0, 3'd2);
    tick();
    checkPtrs("retire.ret0", 2'd2, 1'b0, 3'd1);
    tick();
    checkPtrs("retire.ret1", 2'd2, 1'b0, 3'd0);

    // Mispredict with same-cycle dispatch and CDB_in_1 wakeup.
    doFlush();
    snap_tag_table[7] = 7'd50;
    br_dispatch = 1'b1;
    tick();
    driveIdle();
    setDefaultSnapshot();
    br_dispatch      = 1'b1;
    br_resolve_valid = 1'b1;
    br_resolve_id    = 2'd0;
    br_mispredict    = 1'b1;
    CDB_in_1         = 7'd50;
    #1;
    checkOutput("mixed.recovery_br", 32'(recovery_br), 32'd1);
    checkOutput("mixed.recReady7",   32'(recovery_ready_table[7]), 32'd1);
    checkOutput("mixed.recTag7",     32'(recovery_Tag_table[7]), 32'd50);
    tick();
    driveIdle();
    checkPtrs("mixed.after", 2'd0, 1'b0, 3'd0);

    // Flush beats a same-cycle mispredict.
    doFlush();
    dispatchN(3);
    flush            = 1'b1;
    br_resolve_valid = 1'b1;
    br_resolve_id    = 2'd1;
    br_mispredict    = 1'b1;
    #1;
    checkOutput("flush.recovery_br", 32'(recovery_br), 32'd0);
    checkOutput("flush.recReady",    recovery_ready_table, 32'd0);
    tick();
    driveIdle();
    checkPtrs("flush.after", 2'd0, 1'b0, 3'd0);

    // Reset during a recovery request empties the store.
    dispatchN(3);
    reset            = 1'b1;
    br_resolve_valid = 1'b1;
    br_resolve_id    = 2'd1;
    br_mispredict    = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("rst.recovery_br", 32'(recovery_br), 32'd0);
    checkPtrs("rst.after", 2'd0, 1'b0, 3'd0);
    driveIdle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
